// File: rtl/flash_read_ctrl_if.sv
// Host-side request/acknowledge bundle for flash_read_ctrl.
// master = requester (cartridge bank logic), slave = the controller.
interface flash_read_ctrl_if;
   logic        I_REQ;
   logic [23:0] I_ADDR;
   logic        I_FLUSH;
   logic [7:0]  O_DATA;
   logic        O_ACK;
   logic        O_BUSY;

   modport master (output I_REQ, I_ADDR, I_FLUSH, input O_DATA, O_ACK, O_BUSY);
   modport slave  (input I_REQ, I_ADDR, I_FLUSH, output O_DATA, O_ACK, O_BUSY);
endinterface

// File: rtl/flash_read_ctrl.sv
// Byte-read sequencer for a 16-bit asynchronous parallel flash (CE/ADV/OE timing).
// Optional one-entry word cache enabled by defining FLASH_WORD_CACHE_EN.
module flash_read_ctrl #(
   parameter int unsigned P_WAIT_CYCLES     = 4,
   parameter int unsigned P_RECOVERY_CYCLES = 1
) (
   input  logic               I_CLK,
   input  logic               I_RESET,
   flash_read_ctrl_if.slave   host,
   input  logic [15:0]        I_FLASH_DATA,
   output logic [23:0]        O_FLASH_ADDR,
   output logic               O_FLASH_CE_L,
   output logic               O_FLASH_OE_L,
   output logic               O_ADDR_VALID_L,
   output logic               O_FLASH_WE_L,
   output logic               O_FLASH_CLK
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETUP   = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_RECOVER = 2'd3;

   localparam logic [7:0] WAIT_LOAD    = 8'(P_WAIT_CYCLES - 1);
   localparam logic [7:0] RECOVER_LOAD = 8'(P_RECOVERY_CYCLES - 1);

   logic [1:0] state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       byte_sel;
   logic [7:0] data_q;
   logic       ack_q, busy_q;
   logic       ce_l_q, oe_l_q, adv_l_q;
   logic       hit, accept_miss, capture;

`ifdef FLASH_WORD_CACHE_EN
   logic        cache_vld;
   logic [22:0] cache_tag;
   logic [15:0] cache_word;
   logic        accept_hit;

   // A flush in the same cycle as a matching request forces a miss.
   assign hit        = cache_vld && !host.I_FLUSH && (cache_tag == host.I_ADDR[23:1]);
   assign accept_hit = (state == ST_IDLE) && host.I_REQ && hit;
`else
   logic unused_flush;
   assign unused_flush = host.I_FLUSH;
   assign hit          = 1'b0;
`endif

   assign accept_miss = (state == ST_IDLE) && host.I_REQ && !hit;
   assign capture     = (state == ST_WAIT) && (cnt == '0);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE:  if (accept_miss) state_nx = ST_SETUP;
         ST_SETUP: begin
            state_nx = ST_WAIT;
            cnt_nx   = WAIT_LOAD;
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               if (P_RECOVERY_CYCLES == 0) begin
                  state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_RECOVER;
                  cnt_nx   = RECOVER_LOAD;
               end
            end else begin
               cnt_nx = cnt - 8'd1;
            end
         end
         default: begin
            if (cnt == '0) state_nx = ST_IDLE;
            else           cnt_nx   = cnt - 8'd1;
         end
      endcase
   end

   // Strobes and busy are registered from the next state so they switch cleanly with it.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         byte_sel     <= 1'b0;
         data_q       <= '0;
         ack_q        <= 1'b0;
         busy_q       <= 1'b0;
         ce_l_q       <= 1'b1;
         oe_l_q       <= 1'b1;
         adv_l_q      <= 1'b1;
         O_FLASH_ADDR <= '0;
`ifdef FLASH_WORD_CACHE_EN
         cache_vld    <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         busy_q  <= (state_nx != ST_IDLE);
         ce_l_q  <= !((state_nx == ST_SETUP) || (state_nx == ST_WAIT));
         oe_l_q  <= (state_nx != ST_WAIT);
         adv_l_q <= (state_nx != ST_SETUP);
         ack_q   <= 1'b0;
         if (accept_miss) begin
            O_FLASH_ADDR <= {1'b0, host.I_ADDR[23:1]};
            byte_sel     <= host.I_ADDR[0];
         end
         if (capture) begin
            ack_q  <= 1'b1;
            data_q <= byte_sel ? I_FLASH_DATA[15:8] : I_FLASH_DATA[7:0];
         end
`ifdef FLASH_WORD_CACHE_EN
         if (accept_hit) begin
            ack_q  <= 1'b1;
            data_q <= host.I_ADDR[0] ? cache_word[15:8] : cache_word[7:0];
         end
         if (capture) begin
            cache_word <= I_FLASH_DATA;
            cache_tag  <= O_FLASH_ADDR[22:0];
            cache_vld  <= 1'b1;
         end
         if (host.I_FLUSH) cache_vld <= 1'b0;
`endif
      end
   end

   assign host.O_DATA    = data_q;
   assign host.O_ACK     = ack_q;
   assign host.O_BUSY    = busy_q;
   assign O_FLASH_CE_L   = ce_l_q;
   assign O_FLASH_OE_L   = oe_l_q;
   assign O_ADDR_VALID_L = adv_l_q;
   assign O_FLASH_WE_L   = 1'b1;
   assign O_FLASH_CLK    = 1'b1;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Self-checking bench for flash_read_ctrl: cycle-timeline reference model plus
// directed literal checks; cache scenarios compiled in with FLASH_WORD_CACHE_EN.
module tb_flash_read_ctrl;
   localparam int W = 4;
   localparam int R = 1;
`ifdef FLASH_WORD_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   flash_read_ctrl_if host ();
   flash_read_ctrl_if host2 ();

   logic [15:0] fdata, fdata2;
   logic [15:0] junk = 16'h1234;
   logic [23:0] fa, fa2;
   logic ce_l, oe_l, adv_l, we_l, fclk;
   logic ce2_l, oe2_l, adv2_l, we2_l, fclk2;

   flash_read_ctrl dut (
      .I_CLK(clk), .I_RESET(rst), .host(host), .I_FLASH_DATA(fdata),
      .O_FLASH_ADDR(fa), .O_FLASH_CE_L(ce_l), .O_FLASH_OE_L(oe_l),
      .O_ADDR_VALID_L(adv_l), .O_FLASH_WE_L(we_l), .O_FLASH_CLK(fclk)
   );

   flash_read_ctrl #(.P_WAIT_CYCLES(1), .P_RECOVERY_CYCLES(0)) dut2 (
      .I_CLK(clk), .I_RESET(rst), .host(host2), .I_FLASH_DATA(fdata2),
      .O_FLASH_ADDR(fa2), .O_FLASH_CE_L(ce2_l), .O_FLASH_OE_L(oe2_l),
      .O_ADDR_VALID_L(adv2_l), .O_FLASH_WE_L(we2_l), .O_FLASH_CLK(fclk2)
   );

   // Flash contents; bus carries junk whenever OE is not asserted.
   function automatic logic [15:0] mem_word(input logic [23:0] wa);
      if (wa == 24'h002000) return 16'hBEEF;
      return wa[15:0] ^ {wa[7:0], wa[15:8]} ^ 16'hA5C3;
   endfunction

   assign fdata  = !oe_l  ? mem_word(fa)  : junk;
   assign fdata2 = !oe2_l ? mem_word(fa2) : junk;
   always @(negedge clk) junk = 16'($urandom);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   // Reference model: each miss access is a timeline relative to its accept cycle.
   int          cyc = 0;
   int          acc_n = -1;
   bit          armed = 1'b0;
   logic [23:0] m_addr = '0;
   logic [23:0] exp_fa = '0;
   logic [7:0]  exp_data = '0;
   logic        exp_ack = 1'b0;
   bit          cvalid = 1'b0;
   logic [22:0] ctag = '0;
   logic [15:0] cword = '0;

   always @(posedge clk) begin : model
      bit          idle_now;
      logic [15:0] w;
      logic        ack_n;
      ack_n = 1'b0;
      if (rst) begin
         armed    = 1'b1;
         acc_n    = -1;
         exp_fa   = '0;
         exp_data = '0;
         cvalid   = 1'b0;
      end else if (armed) begin
         idle_now = (acc_n < 0) || (cyc - acc_n >= 2 + W + R);
         if (acc_n >= 0 && cyc == acc_n + 1 + W) begin
            w        = mem_word({1'b0, m_addr[23:1]});
            exp_data = m_addr[0] ? w[15:8] : w[7:0];
            ack_n    = 1'b1;
            cvalid   = 1'b1;
            ctag     = m_addr[23:1];
            cword    = w;
         end
         if (idle_now && host.I_REQ) begin
            if (CACHE_EN && cvalid && !host.I_FLUSH && ctag == host.I_ADDR[23:1]) begin
               exp_data = host.I_ADDR[0] ? cword[15:8] : cword[7:0];
               ack_n    = 1'b1;
            end else begin
               acc_n  = cyc;
               m_addr = host.I_ADDR;
               exp_fa = {1'b0, host.I_ADDR[23:1]};
            end
         end
         if (host.I_FLUSH) cvalid = 1'b0;
      end
      exp_ack = ack_n;
      cyc++;
   end

   always @(negedge clk) begin : compare
      int d;
      bit act;
      if (armed) begin
         d   = cyc - acc_n;
         act = (acc_n >= 0);
         chk("ack",   host.O_ACK,  exp_ack);
         chk("data",  host.O_DATA, exp_data);
         chk("busy",  host.O_BUSY, act && d >= 1 && d <= 1 + W + R);
         chk("ce_l",  ce_l,  !(act && d >= 1 && d <= 1 + W));
         chk("oe_l",  oe_l,  !(act && d >= 2 && d <= 1 + W));
         chk("adv_l", adv_l, !(act && d == 1));
         chk("faddr", fa, exp_fa);
         chk("we_clk", {we_l, fclk}, 2'b11);
      end
   end

   int ack_at[$];
   logic [7:0] ack_dat[$];
   int nack;

   initial begin
      host.I_REQ = 1'b0;  host.I_ADDR = '0;  host.I_FLUSH = 1'b0;
      host2.I_REQ = 1'b0; host2.I_ADDR = '0; host2.I_FLUSH = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("rst_data", host.O_DATA, 8'h00);
      chk("rst_ack", host.O_ACK, 1'b0);
      chk("rst_strobes", {ce_l, oe_l, adv_l}, 3'b111);
      chk("rst_faddr", fa, 24'h0);
      chk("rst_busy2", host2.O_BUSY, 1'b0);

      // Odd byte of 0xBEEF at word 0x002000.
      host.I_REQ = 1'b1; host.I_ADDR = 24'h004001;
      step(); host.I_REQ = 1'b0;
      chk("t1_faddr", fa, 24'h002000);
      chk("t1_busy", host.O_BUSY, 1'b1);
      for (int k = 2; k <= 5; k++) begin
         step();
         chk("t1_oe_low", oe_l, 1'b0);
      end
      step();
      chk("t1_ack", host.O_ACK, 1'b1);
      chk("t1_data", host.O_DATA, 8'hBE);
      step();
      chk("t1_busy_fall", host.O_BUSY, 1'b0);

      host.I_REQ = 1'b1; host.I_ADDR = 24'h004000;
      step(); host.I_REQ = 1'b0;
      repeat (5) step();
      chk("t2_ack", host.O_ACK, 1'b1);
      chk("t2_data", host.O_DATA, 8'hEF);
      step();

      // Request held high: the held-over request is ignored until idle at +7.
      for (int k = 0; k <= 14; k++) begin
         if (host.O_ACK === 1'b1) begin
            ack_at.push_back(k);
            ack_dat.push_back(host.O_DATA);
         end
         host.I_REQ  = (k <= 8);
         host.I_ADDR = (k >= 7) ? 24'h000203 : 24'h000100;
         step();
      end
      host.I_REQ = 1'b0;
      chk("t3_nacks", ack_at.size(), 2);
      chk("t3_ack1_cyc", (ack_at.size() > 0) ? ack_at[0] : -1, 6);
      chk("t3_ack2_cyc", (ack_at.size() > 1) ? ack_at[1] : -1, 13);
      chk("t3_data1", (ack_dat.size() > 0) ? ack_dat[0] : 8'hxx, 8'h43);
      chk("t3_data2", (ack_dat.size() > 1) ? ack_dat[1] : 8'hxx, 8'hA5);

      // Reset during WAIT aborts the read.
      host.I_REQ = 1'b1; host.I_ADDR = 24'h004001;
      step(); host.I_REQ = 1'b0;
      step();
      step(); rst = 1'b1;
      step(); rst = 1'b0;
      chk("t4_ce_oe", {ce_l, oe_l}, 2'b11);
      chk("t4_data", host.O_DATA, 8'h00);
      nack = 0;
      for (int k = 0; k < 8; k++) begin
         if (host.O_ACK === 1'b1) nack++;
         step();
      end
      chk("t4_no_ack", nack, 0);

      // Minimum timing instance: one wait cycle, no recovery.
      host2.I_REQ = 1'b1; host2.I_ADDR = 24'h004001;
      step(); step(); step();
      chk("t5_ack", host2.O_ACK, 1'b1);
      chk("t5_data", host2.O_DATA, 8'hBE);
      chk("t5_busy", host2.O_BUSY, 1'b0);
      host2.I_ADDR = 24'h004000;
      step(); host2.I_REQ = 1'b0;
      chk("t5_reaccept", host2.O_BUSY, 1'b1);
      step(); step();
      chk("t5_ack2", host2.O_ACK, 1'b1);
      chk("t5_data2", host2.O_DATA, 8'hEF);
      step();

`ifdef FLASH_WORD_CACHE_EN
      host.I_REQ = 1'b1; host.I_ADDR = 24'h000010;
      step(); host.I_REQ = 1'b0;
      repeat (5) step();
      chk("t6_miss_data", host.O_DATA, 8'hCB);
      step();
      host.I_REQ = 1'b1; host.I_ADDR = 24'h000011;
      step();
      chk("t6_hit_ack", host.O_ACK, 1'b1);
      chk("t6_hit_data", host.O_DATA, 8'hAD);
      chk("t6_hit_ce", ce_l, 1'b1);
      chk("t6_hit_busy", host.O_BUSY, 1'b0);
      host.I_ADDR = 24'h000010;
      step();
      chk("t6_hit2_data", host.O_DATA, 8'hCB);
      host.I_REQ = 1'b0; host.I_FLUSH = 1'b1;
      step();
      host.I_FLUSH = 1'b0; host.I_REQ = 1'b1; host.I_ADDR = 24'h000011;
      step(); host.I_REQ = 1'b0;
      chk("t6_flush_busy", host.O_BUSY, 1'b1);
      repeat (5) step();
      chk("t6_flush_ack", host.O_ACK, 1'b1);
      chk("t6_flush_data", host.O_DATA, 8'hAD);
      step();
`endif

      for (int i = 0; i < 3000; i++) begin
         host.I_REQ = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) == 0) host.I_ADDR = 24'($urandom);
         else host.I_ADDR = 24'h000010 | 24'($urandom_range(0, 3));
         host.I_FLUSH = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0; host.I_REQ = 1'b0; host.I_FLUSH = 1'b0;
      repeat (12) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/flash_read_ctrl.md
# flash_read_ctrl

Sequencer between the cartridge ROM path and the board's 16-bit asynchronous parallel flash. It accepts single-byte read requests on a byte address and runs a timed CE/ADV/OE access cycle with a programmable wait count. It captures the 16-bit flash word and returns the selected byte with a one-cycle acknowledge. The cartridge bank logic feeds it from upstream, so no raw flash timing is exposed to the CPU-side clock domain.

## Interface
- P_WAIT_CYCLES, 4: cycles OE_L is held low before data is sampled; legal range 1–255.
- P_RECOVERY_CYCLES, 1: cycles CE_L/OE_L are held high after a capture before the next access; legal range 0–255.

- I_CLK  in  1  sole clock; all logic on posedge.
- I_RESET  in  1  synchronous, active-high reset.
- I_REQ  in  1  read request; sampled only when idle.
- I_ADDR  in  24  byte address; sampled with an accepted I_REQ.
- I_FLUSH  in  1  invalidates the word cache; ignored when the cache is compiled out.
- O_DATA  out  8  returned byte; valid while O_ACK=1 and held until the next ACK.
- O_ACK  out  1  one-cycle pulse; read complete.
- O_BUSY  out  1  high whenever state≠IDLE.
- I_FLASH_DATA  in  16  flash data bus.
- O_FLASH_ADDR  out  24  flash word address = {1'b0, addr[23:1]}.
- O_FLASH_CE_L, O_FLASH_OE_L, O_ADDR_VALID_L  out  1 each  flash strobes, active-low.
- O_FLASH_WE_L, O_FLASH_CLK  out  1 each  tied to 1; the flash runs in asynchronous read mode.

## Operation
- States: IDLE, SETUP, WAIT, RECOVER.
- IDLE: CE_L=OE_L=ADV_L=1.
  - I_REQ=1 latches I_ADDR.
  - O_FLASH_ADDR is loaded and the state moves to SETUP.
- SETUP: lasts 1 cycle, with CE_L=0 and ADV_L=0. The wait counter loads P_WAIT_CYCLES-1. Next state is WAIT.
- WAIT: CE_L=0, OE_L=0, ADV_L=1. The counter decrements each cycle.
  - When the counter reaches 0, I_FLASH_DATA is registered.
  - The byte is selected: addr[0]=0 gives [7:0]; addr[0]=1 gives [15:8].
  - O_DATA and O_ACK are registered.
  - The state moves to RECOVER, or to IDLE if P_RECOVERY_CYCLES=0.
- RECOVER: all strobes are high for P_RECOVERY_CYCLES cycles, then the state returns to IDLE.
- I_REQ asserted while busy is ignored, not queued. The requester must wait for O_BUSY=0.
- O_FLASH_ADDR holds its last value between accesses.
- O_ACK never asserts for a request that was not accepted.
- Reset (any state, including mid-access) returns to IDLE with:
  - O_DATA=0, O_ACK=0, O_BUSY=0
  - CE_L=OE_L=ADV_L=1
  - O_FLASH_ADDR=0
  - the cache invalidated
- A read aborted by reset produces no ACK.

## Timing
- Count the cycle in which I_REQ is sampled high in IDLE as N.
  - SETUP occupies N+1.
  - WAIT occupies N+2 … N+1+P_WAIT_CYCLES.
  - O_ACK and O_DATA are valid in cycle N+2+P_WAIT_CYCLES.
- With defaults, O_ACK is in N+6 and the next request is accepted in N+7.
- Miss throughput is one read every 2+P_WAIT_CYCLES+P_RECOVERY_CYCLES cycles, at least 3.
- O_BUSY is registered. It rises in N+1 and falls in the first IDLE cycle.
- I_FLASH_DATA is sampled at the clock edge ending the last WAIT cycle.

## Configuration
- FLASH_WORD_CACHE_EN defined:
  - A one-entry cache stores the last captured word, its word address, and a valid bit.
  - An IDLE request whose addr[23:1] matches a valid entry is a hit. A hit does not start a flash cycle and the strobes stay high.
  - On a hit, O_ACK and O_DATA are valid in N+1 and O_BUSY stays 0, so back-to-back hits are accepted every cycle.
  - I_FLUSH=1 clears the valid bit on the next edge. If I_FLUSH and a hit request occur in the same cycle, the flush wins and the request is treated as a miss.
- FLASH_WORD_CACHE_EN undefined:
  - No cache; every request runs the full flash cycle.
  - I_FLUSH is unused.

## Test plan
- Reset, then a request to I_ADDR=0x004001 with flash word 0xBEEF at word 0x002000, defaults:
  - O_FLASH_ADDR=0x002000.
  - OE_L is low in N+2…N+5.
  - O_ACK and O_DATA=0xBE appear in N+6.
  - O_BUSY=0 in N+7.
- Same word, I_ADDR=0x004000 → O_DATA=0xEF.
- I_REQ held high from N to N+8 → exactly two ACKs (N+6 and N+13); the second read uses the address sampled at N+7.
- I_RESET asserted in N+3 mid-WAIT → CE_L and OE_L are 1 in N+4, there is no ACK, and O_DATA=0.
- With P_WAIT_CYCLES=1 and P_RECOVERY_CYCLES=0 → ACK in N+3, next request accepted in N+3.
- With FLASH_WORD_CACHE_EN, read 0x000010 then 0x000011:
  - The second read gives ACK in N+1 with no CE_L toggle.
  - After I_FLUSH, the same address takes the full 6-cycle path.
